// File: rtl/pulse_timer.sv
// pulse_timer: programmable periodic / one-shot pulse generator.
// A CNT_W-bit period counter runs from 0 to div_r-1; pulse_out is high for
// the first width_r counts of each period and done strobes once per period.
module pulse_timer #(
  parameter int CNT_W       = 19,
  parameter int PW_W        = 8,
  parameter int DEFAULT_DIV = 500000,
  parameter int DEFAULT_PW  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [CNT_W-1:0] divisor,
  input  logic [PW_W-1:0]  width,
  input  logic             trig,
  output logic             pulse_out,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {IDLE, RUN, SHOT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] div_r, div_nxt;
  logic [PW_W-1:0]  width_r, width_nxt;
  logic             pulse_nxt, done_nxt;
  logic             active;
  logic             in_window;

  assign active = (state != IDLE);
  assign busy   = active;

  // Compare in a common width so any CNT_W/PW_W combination is exact.
  assign in_window = ({{PW_W{1'b0}}, count} < {{CNT_W{1'b0}}, width_r});

  // State and configuration registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      div_r     <= CNT_W'(DEFAULT_DIV);
      width_r   <= PW_W'(DEFAULT_PW);
      pulse_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      div_r     <= div_nxt;
      width_r   <= width_nxt;
      pulse_out <= pulse_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state / next-output logic. Priority: en=0 > load > trig/advance.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    done_nxt  = 1'b0;
    pulse_nxt = active && in_window;
    // Config is captured on any load, independent of state and en.
    div_nxt   = load ? divisor : div_r;
    width_nxt = load ? width   : width_r;

    if (!en) begin
      // Abort: no done for the interrupted period, output drops at once.
      state_nxt = IDLE;
      count_nxt = '0;
      pulse_nxt = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          count_nxt = '0;
          // Start decisions use the config being loaded this cycle, so a
          // load+trig pair launches a shot with the new values.
          if (div_nxt != '0) begin
            if (!mode)     state_nxt = RUN;
            else if (trig) state_nxt = SHOT;
          end
        end
        RUN, SHOT: begin
          if (div_nxt == '0) begin
            // A zero period cannot run; fall back to IDLE silently.
            state_nxt = IDLE;
            count_nxt = '0;
            pulse_nxt = 1'b0;
          end else if (load) begin
            // Restart the period under the new config, state unchanged.
            count_nxt = '0;
          end else if (count >= div_r - CNT_W'(1)) begin
            count_nxt = '0;
            done_nxt  = 1'b1;
            if (state == SHOT) state_nxt = IDLE;
          end else begin
            count_nxt = count + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          count_nxt = '0;
          pulse_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_timer.sv
// Directed bench for pulse_timer: hand-computed cycle-by-cycle expectations.
module tb_pulse_timer;

  localparam int CNT_W = 19;
  localparam int PW_W  = 8;
  localparam int DDIV  = 10;

  logic             clk = 1'b0;
  logic             reset, en, mode, load, trig;
  logic [CNT_W-1:0] divisor;
  logic [PW_W-1:0]  width;
  logic             pulse_out, done, busy;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;

  pulse_timer #(.CNT_W(CNT_W), .PW_W(PW_W), .DEFAULT_DIV(DDIV), .DEFAULT_PW(1)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load),
    .divisor(divisor), .width(width), .trig(trig),
    .pulse_out(pulse_out), .done(done), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; trig = 1'b0;
    divisor = '0; width = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_cfg(input int d, input int w);
    load = 1'b1; divisor = CNT_W'(d); width = PW_W'(w);
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    // Reset must win over load/en/trig presented in the same cycle.
    reset = 1'b1; en = 1'b1; mode = 1'b1; trig = 1'b1;
    load = 1'b1; divisor = 19'd7; width = 8'd3;
    tick();
    reset = 1'b0; load = 1'b0; trig = 1'b0; en = 1'b0; mode = 1'b0;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b exp 0", pulse_out); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (count !== '0)       begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
  endtask

  task automatic test_periodic();
    do_reset();
    load_cfg(4, 1);
    en = 1'b1; mode = 1'b0;
    tick();  // entry edge: RUN, count 0
    for (int k = 0; k < 12; k++) begin
      if (k == 6) mode = 1'b1;  // ignored outside IDLE
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL periodic_busy k=%0d got %b exp 1", k, busy); end
      checks++; if (count !== CNT_W'(k % 4)) begin errors++; $display("FAIL periodic_count k=%0d got %0d exp %0d", k, count, k % 4); end
      checks++; if (pulse_out !== (k % 4 == 1)) begin errors++; $display("FAIL periodic_pulse k=%0d got %b exp %b", k, pulse_out, (k % 4 == 1)); end
      checks++; if (done !== (k > 0 && k % 4 == 0)) begin errors++; $display("FAIL periodic_done k=%0d got %b exp %b", k, done, (k > 0 && k % 4 == 0)); end
      tick();
    end
    en = 1'b0; mode = 1'b0;
  endtask

  task automatic test_full_width();
    do_reset();
    load_cfg(4, 5);
    en = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      checks++; if (pulse_out !== (k > 0)) begin errors++; $display("FAIL fullw_pulse k=%0d got %b exp %b", k, pulse_out, (k > 0)); end
      checks++; if (done !== (k > 0 && k % 4 == 0)) begin errors++; $display("FAIL fullw_done k=%0d got %b exp %b", k, done, (k > 0 && k % 4 == 0)); end
      tick();
    end
    en = 1'b0;
  endtask

  task automatic test_oneshot();
    int ndone;
    bit eb, ep, ed;
    ndone = 0;
    do_reset();
    load_cfg(3, 2);
    en = 1'b1; mode = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL shot_wait_busy got %b exp 0", busy); end
    trig = 1'b1;
    tick();  // entry edge
    trig = 1'b0;
    for (int k = 0; k < 9; k++) begin
      eb = (k < 3); ep = (k == 1 || k == 2); ed = (k == 3);
      checks++; if (busy !== eb) begin errors++; $display("FAIL shot_busy k=%0d got %b exp %b", k, busy, eb); end
      checks++; if (pulse_out !== ep) begin errors++; $display("FAIL shot_pulse k=%0d got %b exp %b", k, pulse_out, ep); end
      checks++; if (done !== ed) begin errors++; $display("FAIL shot_done k=%0d got %b exp %b", k, done, ed); end
      if (done === 1'b1) ndone++;
      trig = (k == 1);  // retrigger during SHOT must be ignored
      tick();
      trig = 1'b0;
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL shot_count got %0d exp 1", ndone); end
    en = 1'b0; mode = 1'b0;
  endtask

  task automatic test_load_trig();
    do_reset();
    en = 1'b1; mode = 1'b1;
    load = 1'b1; divisor = 19'd5; width = 8'd3; trig = 1'b1;
    tick();
    load = 1'b0; trig = 1'b0;
    for (int k = 0; k < 7; k++) begin
      checks++; if (busy !== (k < 5)) begin errors++; $display("FAIL ldtrig_busy k=%0d got %b exp %b", k, busy, (k < 5)); end
      checks++; if (done !== (k == 5)) begin errors++; $display("FAIL ldtrig_done k=%0d got %b exp %b", k, done, (k == 5)); end
      tick();
    end
    en = 1'b0; mode = 1'b0;
  endtask

  task automatic test_zero_div();
    int bad;
    bad = 0;
    do_reset();
    load_cfg(0, 1);
    en = 1'b1; mode = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (busy !== 1'b0 || pulse_out !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL zero_div active_cycles got %0d exp 0", bad); end
    en = 1'b0;
  endtask

  task automatic test_reload();
    do_reset();
    load_cfg(4, 1);
    en = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (count !== 19'd2) begin errors++; $display("FAIL reload_pre_count got %0d exp 2", count); end
    load = 1'b1; divisor = 19'd6; width = 8'd1;
    tick();
    load = 1'b0;
    checks++; if (count !== 19'd0) begin errors++; $display("FAIL reload_count got %0d exp 0", count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reload_busy got %b exp 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reload_done0 got %b exp 0", done); end
    for (int j = 1; j <= 12; j++) begin
      tick();
      checks++; if (done !== (j == 6 || j == 12)) begin errors++; $display("FAIL reload_done j=%0d got %b exp %b", j, done, (j == 6 || j == 12)); end
      checks++; if (count !== CNT_W'(j % 6)) begin errors++; $display("FAIL reload_cnt j=%0d got %0d exp %0d", j, count, j % 6); end
    end
    en = 1'b0;
  endtask

  task automatic test_en_abort();
    int bad;
    bad = 0;
    do_reset();
    load_cfg(4, 4);
    en = 1'b1;
    tick();
    tick();
    tick();
    en = 1'b0; mode = 1'b1; trig = 1'b1;  // trig must be ignored while disabled
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (count !== '0)  begin errors++; $display("FAIL abort_count got %0d exp 0", count); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done); end
    for (int k = 0; k < 5; k++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_hold got %0d exp 0", bad); end
    trig = 1'b0; mode = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    load_cfg(4, 1);
    en = 1'b1; mode = 1'b0;
    tick();
    tick();
    tick();
    tick();
    checks++; if (count !== 19'd3) begin errors++; $display("FAIL rstrun_pre_count got %0d exp 3", count); end
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || pulse_out !== 1'b0 || done !== 1'b0 || count !== '0) begin
      errors++; $display("FAIL rstrun_outputs got busy=%b pulse=%b done=%b count=%0d exp all 0", busy, pulse_out, done, count);
    end
    reset = 1'b0;
    tick();  // entry edge with default divisor
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++; if (done !== (k == DDIV || k == 2 * DDIV)) begin errors++; $display("FAIL rstrun_done k=%0d got %b exp %b", k, done, (k == DDIV || k == 2 * DDIV)); end
      checks++; if (pulse_out !== (k % DDIV == 1)) begin errors++; $display("FAIL rstrun_pulse k=%0d got %b exp %b", k, pulse_out, (k % DDIV == 1)); end
    end
    en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; trig = 1'b0;
    divisor = '0; width = '0;
    #2;
    test_reset();
    test_periodic();
    test_full_width();
    test_oneshot();
    test_load_trig();
    test_zero_div();
    test_reload();
    test_en_abort();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
